button_conditioner: RTL and testbench

//  Front end for the calculator's 9 push-buttons. It sits directly upstream of the

---
 rtl/button_conditioner.sv | 144 ++++++++++++++
 tb/tb_button_conditioner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: per-bit 2-FF synchroniser, debounce, press strobe and
// optional auto-repeat. All outputs are registered and every bit is independent.
module button_conditioner #(
  parameter int               N_BTN         = 9,
  parameter int               DEBOUNCE_CYC  = 500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 9'h00F,
  parameter int               REPEAT_DELAY  = 50000000,
  parameter int               REPEAT_PERIOD = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam int CW   = $clog2(DEBOUNCE_CYC);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_t;

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] level_r;
  logic [N_BTN-1:0] pulse_r;
  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] pulse_s;
  logic [CW-1:0]    cnt_r  [N_BTN];
  logic [CW-1:0]    cnt_s  [N_BTN];
  rpt_state_t       state_r[N_BTN];
  rpt_state_t       state_s[N_BTN];
  logic [RW-1:0]    rcnt_r [N_BTN];
  logic [RW-1:0]    rcnt_s [N_BTN];

  // Debounce: a change is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    level_s = level_r;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_s[i] = '0;
      if (sync2_r[i] == level_r[i]) begin
        cnt_s[i] = '0;
      end else if (cnt_r[i] == DB_LAST) begin
        level_s[i] = sync2_r[i];
        cnt_s[i]   = '0;
      end else begin
        cnt_s[i] = cnt_r[i] + 1'b1;
      end
    end
  end

  // Press strobe plus auto-repeat; a falling level aborts the repeat in the same cycle.
  always_comb begin
    pulse_s = level_s & ~level_r;
    for (int i = 0; i < N_BTN; i++) begin
      state_s[i] = state_r[i];
      rcnt_s[i]  = rcnt_r[i];
      if (!REPEAT_MASK[i] || !level_s[i]) begin
        state_s[i] = ST_IDLE;
        rcnt_s[i]  = '0;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            if (pulse_s[i]) begin
              state_s[i] = ST_WAIT;
              rcnt_s[i]  = '0;
            end else begin
              state_s[i] = ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (rcnt_r[i] == DLY_LAST) begin
              pulse_s[i] = 1'b1;
              rcnt_s[i]  = '0;
              state_s[i] = ST_RPT;
            end else begin
              rcnt_s[i] = rcnt_r[i] + 1'b1;
            end
          end
          ST_RPT: begin
            if (rcnt_r[i] == PER_LAST) begin
              pulse_s[i] = 1'b1;
              rcnt_s[i]  = '0;
            end else begin
              rcnt_s[i] = rcnt_r[i] + 1'b1;
            end
          end
          default: begin
            state_s[i] = ST_IDLE;
            rcnt_s[i]  = '0;
          end
        endcase
      end
    end
  end

  // Synchroniser, debounced level and output strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      level_r <= '0;
      pulse_r <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      level_r <= level_s;
      pulse_r <= pulse_s;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  // Auto-repeat state and interval counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= ST_IDLE;
        rcnt_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= state_s[i];
        rcnt_r[i]  <= rcnt_s[i];
      end
    end
  end

  assign btn_level = level_r;
  assign btn_pulse = pulse_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: table vectors, hand-written corner
// sequences and a per-cycle comparison against an arithmetic reference model.
module tb_button_conditioner;

  localparam int         NB   = 9;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [8:0] MASK = 9'h00F;

  logic       clk;
  logic       rst;
  logic [8:0] btn_raw;
  logic [8:0] btn_level;
  logic [8:0] btn_pulse;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYC(DB), .REPEAT_MASK(MASK),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each bit accepts a new value once the synchronised sample
  // (raw from two edges back) has disagreed for DB edges in a row; pulses fall at
  // rise edge P, P+RD, P+RD+k*RP while the level stays high.
  typedef struct packed {
    logic lv;
    logic p;
    int   run;
    int   rise;
  } mst_t;

  mst_t       m_st[NB];
  logic [8:0] m_hist[4];
  int         m_n;
  logic [8:0] m_level;
  logic [8:0] m_pulse;

  function automatic mst_t bit_step(input logic sv, input mst_t cur, input int n, input logic rmask);
    mst_t nx;
    int   d;
    nx   = cur;
    nx.p = 1'b0;
    if (sv != cur.lv) begin
      if (cur.run + 1 == DB) begin
        nx.lv  = sv;
        nx.run = 0;
        if (sv) nx.rise = n;
      end else begin
        nx.run = cur.run + 1;
      end
    end else begin
      nx.run = 0;
    end
    d    = n - nx.rise;
    nx.p = nx.lv && (d == 0 || (rmask && d >= RD && ((d - RD) % RP) == 0));
    return nx;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n <= 0;
      for (int i = 0; i < NB; i++) m_st[i] <= '0;
    end else begin
      m_hist[m_n % 4] <= btn_raw;
      m_n <= m_n + 1;
      for (int i = 0; i < NB; i++)
        m_st[i] <= bit_step((m_n >= 2) ? m_hist[(m_n - 2) % 4][i] : 1'b0, m_st[i], m_n, MASK[i]);
    end
  end

  always_comb begin
    m_level = '0;
    m_pulse = '0;
    for (int i = 0; i < NB; i++) begin
      m_level[i] = m_st[i].lv;
      m_pulse[i] = m_st[i].p;
    end
  end

  always @(negedge clk) begin
    chk("model_level", int'(btn_level), int'(m_level));
    chk("model_pulse", int'(btn_pulse), int'(m_pulse));
  end

  typedef struct {
    logic [8:0] raw;
    int         hold;
    logic [8:0] exp_first;
    int         exp_np;
    int         exp_lat;
    logic [8:0] exp_hi;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    btn_raw = '0;
    repeat (DB + 10) tick();
    chk("idle_level", int'(btn_level), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [8:0] first;
    logic [8:0] hi;
    logic [8:0] lo;
    int         np;
    int         lat;
    first   = '0;
    hi      = '0;
    lo      = '1;
    np      = 0;
    lat     = -1;
    btn_raw = v.raw;
    for (int e = 0; e < v.hold + 12; e++) begin
      tick();
      if (btn_pulse != '0) begin
        if (np == 0) begin
          first = btn_pulse;
          lat   = e;
        end
        np++;
      end
      if (e == v.hold + 4) hi = btn_level;
      if (e == v.hold + 5) lo = btn_level;
      if (e == v.hold - 1) btn_raw = '0;
    end
    chk($sformatf("vec%0d_first", idx), int'(first), int'(v.exp_first));
    chk($sformatf("vec%0d_npulse", idx), np, v.exp_np);
    chk($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("vec%0d_level_held", idx), int'(hi), int'(v.exp_hi));
    chk($sformatf("vec%0d_level_fall", idx), int'(lo), 0);
  endtask

  initial begin
    int edges[$];
    int expq[$];
    int np0;
    int e0;

    vecs[0] = '{9'h020, 3,  9'h000, 0,  -1, 9'h000};
    vecs[1] = '{9'h004, 4,  9'h004, 1,  5,  9'h004};
    vecs[2] = '{9'h080, 40, 9'h080, 1,  5,  9'h080};
    vecs[3] = '{9'h002, 40, 9'h002, 11, 5,  9'h002};
    vecs[4] = '{9'h044, 20, 9'h044, 5,  5,  9'h044};
    vecs[5] = '{9'h003, 12, 9'h003, 2,  5,  9'h003};

    // Reset with every button held, then release.
    rst     = 1'b0;
    btn_raw = 9'h1FF;
    repeat (3) tick();
    chk("rst_level", int'(btn_level), 0);
    chk("rst_pulse", int'(btn_pulse), 0);
    rst = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 4) chk("rel_level_early", int'(btn_level), 0);
      if (e == 5) begin
        chk("rel_level", int'(btn_level), 9'h1FF);
        chk("rel_pulse", int'(btn_pulse), 9'h1FF);
      end
      if (e == 6) chk("rel_pulse_once", int'(btn_pulse), 0);
    end
    idle();

    for (int k = 0; k < 6; k++) begin
      run_vec(k, vecs[k]);
      idle();
    end

    // Bounce on button 0: 1,0,1,0 then held.
    np0 = 0;
    e0  = -1;
    for (int e = 0; e < 25; e++) begin
      btn_raw[0] = (e < 4) ? ((e % 2) == 0) : (e < 12);
      tick();
      if (btn_pulse[0]) begin
        np0++;
        e0 = e;
      end
    end
    chk("bounce_npulse", np0, 1);
    chk("bounce_edge", e0, 9);
    idle();

    // Exact auto-repeat schedule on button 1.
    btn_raw = 9'h002;
    for (int e = 0; e < 52; e++) begin
      tick();
      if (btn_pulse[1]) edges.push_back(e);
      if (e == 39) btn_raw = '0;
    end
    expq.push_back(5);
    for (int t = 5 + RD; t <= 44; t += RP) expq.push_back(t);
    chk("rpt_count", edges.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < edges.size()) chk("rpt_edge", edges[i], expq[i]);
    idle();

    // Simultaneous press, then reset in the middle of the hold.
    btn_raw = 9'h044;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 5) chk("simul_pulse", int'(btn_pulse), 9'h044);
    end
    rst = 1'b0;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_pulse", int'(btn_pulse), 0);
    repeat (3) tick();
    chk("midrst_hold", int'(btn_level), 0);
    rst = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 4) chk("repulse_early", int'(btn_level), 0);
      if (e == 5) begin
        chk("repulse_pulse", int'(btn_pulse), 9'h044);
        chk("repulse_level", int'(btn_level), 9'h044);
      end
      if (e == 6) chk("repulse_once", int'(btn_pulse), 0);
    end
    idle();

    // Random presses and occasional resets, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 15) == 0) btn_raw[b] = ~btn_raw[b];
      rst = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
